audio_serial_port: RTL and testbench
====================================

// Module: audio_serial_port
// PURPOSE
//  Codec-side end of the audio read/write handshake used by the top-level lab designs.
//  Deserialises I2S ADC data (AUD_ADCDAT) into left/right sample pairs for read/read_ready.
//  Serialises pairs taken on write/write_ready onto AUD_DACDAT; both paths are FIFO-buffered.
//  Sits between the AUD_* pins (codec is bit/frame-clock master) and user logic on CLOCK_50.
// PARAMETERS
//  DATA_W      24  sample width per channel (MSB-first on the wire)
//  FIFO_DEPTH  8   pairs per direction; power of 2, >=2
//  SYNC_STAGES 2   flip-flops synchronising AUD_BCLK/AUD_ADCLRCK/AUD_DACLRCK/AUD_ADCDAT
// PORTS
//  CLOCK_50        in   1       system clock; all logic on its rising edge
//  reset           in   1       asynchronous, active-high reset
//  read            in   1       pop one ADC pair; honoured only while read_ready=1
//  write           in   1       push one DAC pair; honoured only while write_ready=1
//  writedata_left  in   DATA_W  DAC left sample, taken with write
//  writedata_right in   DATA_W  DAC right sample, taken with write
//  AUD_ADCDAT      in   1       serial ADC data from codec
//  AUD_BCLK        in   1       bit clock from codec (async to CLOCK_50, <= CLOCK_50/8)
//  AUD_ADCLRCK     in   1       ADC frame clock: 0 = left, 1 = right
//  AUD_DACLRCK     in   1       DAC frame clock: 0 = left, 1 = right
//  read_ready      out  1       ADC FIFO not empty
//  write_ready     out  1       DAC FIFO not full
//  readdata_left   out  DATA_W  head-of-ADC-FIFO left sample (show-ahead)
//  readdata_right  out  DATA_W  head-of-ADC-FIFO right sample (show-ahead)
//  AUD_DACDAT      out  1       serial DAC data to codec
// BEHAVIOUR
//  Reset: all outputs 0, both FIFOs empty, bit counters 0, both paths IDLE; partial frame discarded.
//  Sync/edge: inputs pass SYNC_STAGES FFs; BCLK rise/fall and LRCK fall/rise are 1-cycle pulses
//   from the last two sync stages. Every "edge" below means the synchronised pulse.
//  Frame: I2S, 1-BCLK delay; frame starts on LRCK fall (left), right half starts on LRCK rise.
//  ADC FSM IDLE->LEFT->RIGHT->LEFT...: IDLE leaves only on LRCK fall (no partial first frame).
//   On each LRCK edge, bit count=0. On BCLK rise, count++; counts 2..DATA_W+1 shift ADCDAT in
//   MSB-first; later bits ignored. On LRCK fall from RIGHT, {left,right} pushed to ADC FIFO.
//   ADC FIFO full at push and no pop that cycle -> pair dropped, FIFO unchanged.
//  Read side: read_ready/readdata are registered FIFO state, updated the cycle after push/pop.
//   read=1 with read_ready=1 pops one pair per cycle. read=1 with read_ready=0 is ignored.
//  DAC FSM IDLE->LEFT->RIGHT->LEFT...: IDLE leaves on DACLRCK fall. At each DACLRCK fall, pop
//   one pair into the tx regs if the FIFO is non-empty; if empty, load zeros (underrun = silence).
//   Channel shift reg loads left at DACLRCK fall and right at DACLRCK rise.
//   On each BCLK fall after an LRCK edge, drive the next bit (MSB first).
//   Bit N lands on the (N+1)th fall, so MSB is valid on the 2nd BCLK rise.
//   Bits past DATA_W drive 0. AUD_DACDAT=0 in IDLE.
//  Write side: write=1 & write_ready=1 pushes one pair per cycle.
//   write=1 while full is ignored, no corruption.
//  Simultaneous push+pop on one FIFO: both succeed, occupancy unchanged (incl. full and empty).
//  Pointers: log2(FIFO_DEPTH)+1 bits; wrap naturally; full = MSBs differ and the rest equal.
//  Reset mid-frame: async clear; after release each path waits in IDLE for its next LRCK fall.
// STRUCTURE
//  Package audio_pkg: DATA_W default and typedef struct packed {logic [DATA_W-1:0] l, r;} sample_pair_t.
//  Sub-module sync_fifo (sample_pair_t data, FIFO_DEPTH, show-ahead, sync push/pop, full/empty),
//   instantiated twice (ADC path, DAC path).
//  The rest lives in this module: synchronisers, edge detect, ADC and DAC FSMs, shift regs.
// TESTING (BFM: BCLK = CLOCK_50/16, 32 BCLK per channel, DATA_W=24)
//  1. Codec sends L=24'hA5A5A5, R=24'h5A5A5A, one frame -> read_ready=1 after frame end;
//     readdata = A5A5A5/5A5A5A; read pulse -> read_ready=0 next cycle.
//  2. write L=24'h800001, R=24'h7FFFFE before DACLRCK fall -> BFM decodes exactly those words
//     in the next frame; following frame with FIFO empty decodes 0/0.
//  3. 10 ADC frames, no reads (DEPTH 8) -> frames 1..8 read back in order; 9 and 10 lost;
//     read_ready low after 8 pops.
//  4. 9 writes back-to-back -> write_ready low after the 8th; 9th ignored; 8 frames transmitted
//     in order, then zeros.
//  5. Pulse reset mid-left-channel -> outputs 0 within one cycle; the partial frame is never
//     delivered; the first full frame after release is read correctly.
//  6. FIFO full, read and ADC push in the same cycle -> both take effect, read_ready stays 1,
//     order preserved.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared types for the codec-side audio serial port.
// Sample width, the left/right pair bundle and path state encoding.
package audio_pkg;

   localparam int DATA_W = 24;
   localparam int CNT_W  = 6;

   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   typedef struct packed {
      logic [DATA_W-1:0] l;
      logic [DATA_W-1:0] r;
   } sample_pair_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LEFT,
      S_RIGHT
   } path_state_t;

endpackage

// File: rtl/audio_serial_port_if.sv
// User-side read/write handshake of the audio serial port.
// master = user logic, slave = audio_serial_port.
interface audio_serial_port_if;
   import audio_pkg::*;

   logic              read;
   logic              write;
   logic [DATA_W-1:0] writedata_left;
   logic [DATA_W-1:0] writedata_right;
   logic              read_ready;
   logic              write_ready;
   logic [DATA_W-1:0] readdata_left;
   logic [DATA_W-1:0] readdata_right;

   modport master (
      output read, write, writedata_left, writedata_right,
      input  read_ready, write_ready, readdata_left, readdata_right
   );

   modport slave (
      input  read, write, writedata_left, writedata_right,
      output read_ready, write_ready, readdata_left, readdata_right
   );

endinterface

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO of sample pairs.
// Ports: i_push/i_wdata in, i_pop in, o_rdata head, o_full/o_empty flags.
module sync_fifo
   import audio_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_push,
   input  sample_pair_t i_wdata,
   input  logic         i_pop,
   output sample_pair_t o_rdata,
   output logic         o_full,
   output logic         o_empty
);

   localparam int AW = $clog2(DEPTH);

   sample_pair_t r_mem [DEPTH];
   logic [AW:0]  r_wp;
   logic [AW:0]  r_rp;
   logic         w_do_pop;
   logic         w_do_push;

   assign o_empty   = (r_wp == r_rp);
   assign o_full    = (r_wp[AW] != r_rp[AW]) &&
                      (r_wp[AW-1:0] == r_rp[AW-1:0]);
   assign w_do_pop  = i_pop & ~o_empty;
   // A pop frees the slot the push needs, even when full.
   assign w_do_push = i_push & (~o_full | w_do_pop);
   assign o_rdata   = r_mem[r_rp[AW-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wp <= '0;
         r_rp <= '0;
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else begin
         if (w_do_push) begin
            r_mem[r_wp[AW-1:0]] <= i_wdata;
            r_wp <= r_wp + 1'b1;
         end
         if (w_do_pop) r_rp <= r_rp + 1'b1;
      end
   end

endmodule

// File: rtl/audio_serial_port.sv
// Codec-side I2S port: ADC deserialiser and DAC serialiser, FIFO-buffered.
// Ports: CLOCK_50/reset, bus (user handshake), AUD_* codec pins.
module audio_serial_port
   import audio_pkg::*;
#(
   parameter int FIFO_DEPTH  = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic               CLOCK_50,
   input  logic               reset,
   audio_serial_port_if.slave bus,
   input  logic               AUD_ADCDAT,
   input  logic               AUD_BCLK,
   input  logic               AUD_ADCLRCK,
   input  logic               AUD_DACLRCK,
   output logic               AUD_DACDAT
);

   localparam int LS = SYNC_STAGES - 1;

   logic [LS:0] r_bclk_s, r_alr_s, r_dlr_s, r_adat_s;

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         r_bclk_s <= '0;
         r_alr_s  <= '0;
         r_dlr_s  <= '0;
         r_adat_s <= '0;
      end else begin
         r_bclk_s <= {r_bclk_s[LS-1:0], AUD_BCLK};
         r_alr_s  <= {r_alr_s[LS-1:0], AUD_ADCLRCK};
         r_dlr_s  <= {r_dlr_s[LS-1:0], AUD_DACLRCK};
         r_adat_s <= {r_adat_s[LS-1:0], AUD_ADCDAT};
      end
   end

   logic w_bclk_rise, w_bclk_fall;
   logic w_alr_rise, w_alr_fall;
   logic w_dlr_rise, w_dlr_fall;
   logic w_adat;

   assign w_bclk_rise = r_bclk_s[LS-1] & ~r_bclk_s[LS];
   assign w_bclk_fall = ~r_bclk_s[LS-1] & r_bclk_s[LS];
   assign w_alr_rise  = r_alr_s[LS-1] & ~r_alr_s[LS];
   assign w_alr_fall  = ~r_alr_s[LS-1] & r_alr_s[LS];
   assign w_dlr_rise  = r_dlr_s[LS-1] & ~r_dlr_s[LS];
   assign w_dlr_fall  = ~r_dlr_s[LS-1] & r_dlr_s[LS];
   // Data lags BCLK by one stage; it is stable for half a bit anyway.
   assign w_adat      = r_adat_s[LS];

   // ---------------- ADC path ----------------
   path_state_t       r_adc_st;
   logic [CNT_W-1:0]  r_adc_cnt;
   logic [DATA_W-1:0] r_adc_sh;
   logic [DATA_W-1:0] r_adc_l;
   logic              r_adc_push;
   sample_pair_t      r_adc_pair;

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         r_adc_st   <= S_IDLE;
         r_adc_cnt  <= '0;
         r_adc_sh   <= '0;
         r_adc_l    <= '0;
         r_adc_push <= 1'b0;
         r_adc_pair <= '0;
      end else begin
         r_adc_push <= 1'b0;
         if (w_alr_fall) begin
            if (r_adc_st == S_RIGHT) begin
               r_adc_push <= 1'b1;
               r_adc_pair <= '{l: r_adc_l, r: r_adc_sh};
            end
            r_adc_st  <= S_LEFT;
            r_adc_cnt <= '0;
            r_adc_sh  <= '0;
         end else if (w_alr_rise && r_adc_st != S_IDLE) begin
            if (r_adc_st == S_LEFT) r_adc_l <= r_adc_sh;
            r_adc_st  <= S_RIGHT;
            r_adc_cnt <= '0;
            r_adc_sh  <= '0;
         end else if (w_bclk_rise && r_adc_st != S_IDLE) begin
            if (r_adc_cnt != CNT_MAX) r_adc_cnt <= r_adc_cnt + 1'b1;
            // First rise is the I2S delay slot; then DATA_W bits.
            if (r_adc_cnt >= CNT_ONE && r_adc_cnt <= CNT_LAST)
               r_adc_sh <= {r_adc_sh[DATA_W-2:0], w_adat};
         end
      end
   end

   sample_pair_t w_adc_rd;
   logic         w_adc_full, w_adc_empty;
   logic         w_adc_push, w_adc_pop;

   assign w_adc_pop  = bus.read & ~w_adc_empty;
   assign w_adc_push = r_adc_push & (~w_adc_full | w_adc_pop);

   sync_fifo #(.DEPTH(FIFO_DEPTH)) u_adc_fifo (
      .clk     (CLOCK_50),
      .rst     (reset),
      .i_push  (w_adc_push),
      .i_wdata (r_adc_pair),
      .i_pop   (w_adc_pop),
      .o_rdata (w_adc_rd),
      .o_full  (w_adc_full),
      .o_empty (w_adc_empty)
   );

   assign bus.read_ready     = ~w_adc_empty;
   assign bus.readdata_left  = w_adc_rd.l;
   assign bus.readdata_right = w_adc_rd.r;

   // ---------------- DAC path ----------------
   logic         r_rdy_en;
   logic         w_wr_rdy;
   sample_pair_t w_dac_rd, w_dac_wr;
   logic         w_dac_full, w_dac_empty;
   logic         w_dac_push, w_dac_pop;

   // Holds write_ready low until the cycle after reset release.
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) r_rdy_en <= 1'b0;
      else       r_rdy_en <= 1'b1;
   end

   assign w_wr_rdy        = r_rdy_en & ~w_dac_full;
   assign bus.write_ready = w_wr_rdy;
   assign w_dac_wr        = {bus.writedata_left, bus.writedata_right};
   assign w_dac_push      = bus.write & w_wr_rdy;
   assign w_dac_pop       = w_dlr_fall & ~w_dac_empty;

   sync_fifo #(.DEPTH(FIFO_DEPTH)) u_dac_fifo (
      .clk     (CLOCK_50),
      .rst     (reset),
      .i_push  (w_dac_push),
      .i_wdata (w_dac_wr),
      .i_pop   (w_dac_pop),
      .o_rdata (w_dac_rd),
      .o_full  (w_dac_full),
      .o_empty (w_dac_empty)
   );

   path_state_t       r_dac_st;
   logic [CNT_W-1:0]  r_dac_cnt;
   logic [DATA_W-1:0] r_dac_sh;
   logic [DATA_W-1:0] r_dac_tx_r;
   logic              r_dacdat;

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         r_dac_st   <= S_IDLE;
         r_dac_cnt  <= '0;
         r_dac_sh   <= '0;
         r_dac_tx_r <= '0;
         r_dacdat   <= 1'b0;
      end else begin
         if (w_dlr_fall) begin
            // Underrun sends a frame of silence.
            r_dac_st   <= S_LEFT;
            r_dac_cnt  <= '0;
            r_dacdat   <= 1'b0;
            r_dac_sh   <= w_dac_empty ? '0 : w_dac_rd.l;
            r_dac_tx_r <= w_dac_empty ? '0 : w_dac_rd.r;
         end else if (w_dlr_rise && r_dac_st != S_IDLE) begin
            r_dac_st  <= S_RIGHT;
            r_dac_cnt <= '0;
            r_dacdat  <= 1'b0;
            r_dac_sh  <= r_dac_tx_r;
         end else if (w_bclk_fall && r_dac_st != S_IDLE) begin
            if (r_dac_cnt != CNT_MAX) r_dac_cnt <= r_dac_cnt + 1'b1;
            if (r_dac_cnt < CNT_LAST) begin
               r_dacdat <= r_dac_sh[DATA_W-1];
               r_dac_sh <= {r_dac_sh[DATA_W-2:0], 1'b0};
            end else begin
               r_dacdat <= 1'b0;
            end
         end
      end
   end

   assign AUD_DACDAT = r_dacdat;

endmodule

// File: tb/tb_audio_serial_port.sv
// Directed bench for audio_serial_port with an I2S codec model.
// BCLK = CLOCK_50/16, 32 BCLK per channel, shared ADC/DAC frame timing.
module tb_audio_serial_port;
   import audio_pkg::*;

   logic clk = 1'b0;
   logic rst;
   logic adcdat, bclk, alr, dlr;
   logic dacdat;
   logic [23:0] dl, dr;
   int npass = 0;
   int nfail = 0;
   int ntot  = 0;

   audio_serial_port_if bus ();

   audio_serial_port dut (
      .CLOCK_50    (clk),
      .reset       (rst),
      .bus         (bus),
      .AUD_ADCDAT  (adcdat),
      .AUD_BCLK    (bclk),
      .AUD_ADCLRCK (alr),
      .AUD_DACLRCK (dlr),
      .AUD_DACDAT  (dacdat)
   );

   always #10 clk = ~clk;

   task automatic check(input string tag, input logic [47:0] obs,
                        input logic [47:0] exp);
      ntot++;
      assert (obs === exp) npass++;
      else begin
         nfail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic pop();
      @(negedge clk);
      bus.read = 1'b1;
      @(negedge clk);
      bus.read = 1'b0;
   endtask

   task automatic wr(input logic [23:0] l, input logic [23:0] r);
      @(negedge clk);
      bus.write = 1'b1;
      bus.writedata_left = l;
      bus.writedata_right = r;
      @(negedge clk);
      bus.write = 1'b0;
   endtask

   // One I2S frame: sends al/ar on ADCDAT, decodes DACDAT into ol/or_.
   // rdp pulses read in the cycle the previous frame is pushed.
   // rst_slot >= 0 pulses reset in that left-channel slot.
   task automatic frame(input logic [23:0] al, input logic [23:0] ar,
                        input bit rdp, input int rst_slot,
                        output logic [23:0] ol, output logic [23:0] or_);
      logic [23:0] w;
      logic [23:0] d;
      for (int ch = 0; ch < 2; ch++) begin
         w = (ch == 1) ? ar : al;
         d = '0;
         for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            bclk = 1'b0;
            if (k == 0) begin
               alr = (ch == 1);
               dlr = (ch == 1);
            end
            adcdat = (k >= 1 && k <= 24) ? w[24-k] : 1'b0;
            @(negedge clk);
            if (ch == 0 && k == 0 && rdp)
               check("full_before_rd", 48'(bus.read_ready), 48'd1);
            @(negedge clk);
            if (ch == 0 && k == 0 && rdp) bus.read = 1'b1;
            @(negedge clk);
            bus.read = 1'b0;
            if (ch == 0 && k == 0 && rdp)
               check("rr_after_rdpush", 48'(bus.read_ready), 48'd1);
            if (ch == 0 && k == rst_slot) begin
               check("pre_rst_rr", 48'(bus.read_ready), 48'd1);
               rst = 1'b1;
               #1;
               check("rst_rr", 48'(bus.read_ready), 48'd0);
               check("rst_wr", 48'(bus.write_ready), 48'd0);
               check("rst_rd", {bus.readdata_left, bus.readdata_right},
                     48'd0);
               check("rst_dac", 48'(dacdat), 48'd0);
            end
            @(negedge clk);
            rst = 1'b0;
            repeat (4) @(negedge clk);
            bclk = 1'b1;
            if (k >= 1 && k <= 24) d[24-k] = dacdat;
            repeat (7) @(negedge clk);
         end
         if (ch == 0) ol = d;
         else         or_ = d;
      end
   endtask

   initial begin
      rst = 1'b1;
      bclk = 1'b1;
      alr = 1'b1;
      dlr = 1'b1;
      adcdat = 1'b0;
      bus.read = 1'b0;
      bus.write = 1'b0;
      bus.writedata_left = '0;
      bus.writedata_right = '0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst0_rr", 48'(bus.read_ready), 48'd0);
      check("rst0_wr", 48'(bus.write_ready), 48'd0);
      check("rst0_rd", {bus.readdata_left, bus.readdata_right}, 48'd0);
      check("rst0_dac", 48'(dacdat), 48'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check("wr_after_rst", 48'(bus.write_ready), 48'd1);

      // Single ADC frame, single DAC pair, then underrun
      frame(24'hA5A5A5, 24'h5A5A5A, 1'b0, -1, dl, dr);
      check("t1_dac_empty", {dl, dr}, 48'd0);
      check("t1_rr_pending", 48'(bus.read_ready), 48'd0);
      wr(24'h800001, 24'h7FFFFE);
      check("t2_wr_rdy", 48'(bus.write_ready), 48'd1);
      frame(24'h0, 24'h0, 1'b0, -1, dl, dr);
      check("t2_dac_word", {dl, dr}, 48'h800001_7FFFFE);
      check("t1_rr", 48'(bus.read_ready), 48'd1);
      check("t1_rd", {bus.readdata_left, bus.readdata_right},
            48'hA5A5A5_5A5A5A);
      pop();
      check("t1_rr_popped", 48'(bus.read_ready), 48'd0);
      frame(24'h0, 24'h0, 1'b0, -1, dl, dr);
      check("t2_dac_under", {dl, dr}, 48'd0);

      // ADC overflow: 10 frames, only 8 kept
      do_reset();
      for (int i = 1; i <= 10; i++)
         frame(24'(24'h100000 + i), 24'(24'h200000 + i), 1'b0, -1, dl, dr);
      frame(24'h0, 24'h0, 1'b0, -1, dl, dr);
      for (int i = 1; i <= 8; i++) begin
         check("t3_rr", 48'(bus.read_ready), 48'd1);
         check("t3_rd", {bus.readdata_left, bus.readdata_right},
               {24'(24'h100000 + i), 24'(24'h200000 + i)});
         pop();
      end
      check("t3_rr_drained", 48'(bus.read_ready), 48'd0);

      // DAC overflow: 9 writes, 8 kept
      do_reset();
      for (int i = 1; i <= 9; i++) begin
         @(negedge clk);
         if (i == 8) check("t4_wr_rdy7", 48'(bus.write_ready), 48'd1);
         if (i == 9) check("t4_wr_full", 48'(bus.write_ready), 48'd0);
         bus.write = 1'b1;
         bus.writedata_left = 24'(24'h300000 + i);
         bus.writedata_right = 24'(24'h400000 + i);
      end
      @(negedge clk);
      bus.write = 1'b0;
      check("t4_wr_still_full", 48'(bus.write_ready), 48'd0);
      for (int i = 1; i <= 9; i++) begin
         frame(24'h0, 24'h0, 1'b0, -1, dl, dr);
         check("t4_dac", {dl, dr}, (i <= 8) ?
               {24'(24'h300000 + i), 24'(24'h400000 + i)} : 48'd0);
      end

      // Reset in the middle of a left channel
      do_reset();
      frame(24'h111111, 24'h222222, 1'b0, -1, dl, dr);
      frame(24'hFFFFFF, 24'hFFFFFF, 1'b0, 10, dl, dr);
      frame(24'h333333, 24'h444444, 1'b0, -1, dl, dr);
      check("t5_no_partial", 48'(bus.read_ready), 48'd0);
      frame(24'h0, 24'h0, 1'b0, -1, dl, dr);
      check("t5_rr", 48'(bus.read_ready), 48'd1);
      check("t5_rd", {bus.readdata_left, bus.readdata_right},
            48'h333333_444444);
      pop();
      check("t5_rr_popped", 48'(bus.read_ready), 48'd0);

      // Full ADC FIFO: pop and push in the same cycle
      do_reset();
      for (int i = 1; i <= 9; i++)
         frame(24'(24'h500000 + i), 24'(24'h600000 + i), 1'b0, -1, dl, dr);
      frame(24'h0, 24'h0, 1'b1, -1, dl, dr);
      for (int i = 2; i <= 9; i++) begin
         check("t6_rr", 48'(bus.read_ready), 48'd1);
         check("t6_rd", {bus.readdata_left, bus.readdata_right},
               {24'(24'h500000 + i), 24'(24'h600000 + i)});
         pop();
      end
      check("t6_rr_drained", 48'(bus.read_ready), 48'd0);

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
